// File: rtl/pkt_rr_input_arbiter_if.sv
// Word stream bundle: data/ctrl qualified by a write strobe, with a ready flag
// flowing back from the receiver.
interface pkt_rr_input_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, ctrl, wr, input rdy);
  modport slave  (input data, ctrl, wr, output rdy);
endinterface

// File: rtl/pkt_rr_input_arbiter.sv
// Four-input packet-granular round-robin merger: per-input fall-through FIFOs,
// whole packets from one queue at a time, registered output (3 cycles in->out).

module pkt_rr_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             nearly_full_o
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] NF_LEVEL = (DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q;
  logic [DEPTH_BITS-1:0] rd_ptr_q;
  logic [DEPTH_BITS:0]   count_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Fall-through: the head word is visible before it is popped.
  assign dout_o        = mem_q[rd_ptr_q];
  assign empty_o       = (count_q == '0);
  assign nearly_full_o = (count_q >= NF_LEVEL);
endmodule

module pkt_rr_input_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  pkt_rr_input_arbiter_if.slave         in0_i,
  pkt_rr_input_arbiter_if.slave         in1_i,
  pkt_rr_input_arbiter_if.slave         in2_i,
  pkt_rr_input_arbiter_if.slave         in3_i,
  pkt_rr_input_arbiter_if.master        out_o,
  output logic [1:0]                    grant,
  output logic                          busy
);
  localparam int W = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  logic [3:0]   wr_v;
  logic [3:0]   rd_v;
  logic [3:0]   empty_v;
  logic [3:0]   nfull_v;
  logic [W-1:0] din_v  [4];
  logic [W-1:0] dout_v [4];

  assign wr_v     = {in3_i.wr, in2_i.wr, in1_i.wr, in0_i.wr};
  assign din_v[0] = {in0_i.ctrl, in0_i.data};
  assign din_v[1] = {in1_i.ctrl, in1_i.data};
  assign din_v[2] = {in2_i.ctrl, in2_i.data};
  assign din_v[3] = {in3_i.ctrl, in3_i.data};
  assign in0_i.rdy = ~nfull_v[0];
  assign in1_i.rdy = ~nfull_v[1];
  assign in2_i.rdy = ~nfull_v[2];
  assign in3_i.rdy = ~nfull_v[3];

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    pkt_rr_fifo #(
      .WIDTH      (W),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .wr_en_i       (wr_v[g]),
      .din_i         (din_v[g]),
      .rd_en_i       (rd_v[g]),
      .dout_o        (dout_v[g]),
      .empty_o       (empty_v[g]),
      .nearly_full_o (nfull_v[g])
    );
  end

  state_t                state_q;
  logic [1:0]            grant_q;
  logic [1:0]            last_grant_q;
  logic                  in_body_q;
  logic                  busy_q;
  logic                  out_wr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;

  logic [W-1:0]          head;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  rd_en;
  logic                  eop;
  logic                  found_d;
  logic [1:0]            pick_d;
  logic [1:0]            cand;

  assign head      = dout_v[grant_q];
  assign head_ctrl = head[W-1 -: CTRL_WIDTH];
  assign rd_en     = (state_q == XFER) && out_o.rdy && !empty_v[grant_q];
  assign eop       = rd_en && in_body_q && (head_ctrl != '0);
  assign rd_v      = rd_en ? (4'b0001 << grant_q) : 4'b0000;

  // Scan order starts just past the last served queue; last_grant itself is checked last.
  always_comb begin
    found_d = 1'b0;
    pick_d  = grant_q;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!found_d && !empty_v[cand]) begin
        found_d = 1'b1;
        pick_d  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      in_body_q    <= 1'b0;
      busy_q       <= 1'b0;
      out_wr_q     <= 1'b0;
      out_data_q   <= '0;
      out_ctrl_q   <= '0;
    end else begin
      out_wr_q <= rd_en;
      if (rd_en) begin
        out_data_q <= head[DATA_WIDTH-1:0];
        out_ctrl_q <= head_ctrl;
      end
      case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q <= pick_d;
            state_q <= XFER;
            busy_q  <= 1'b1;
          end
        end
        XFER: begin
          if (eop) begin
            last_grant_q <= grant_q;
            in_body_q    <= 1'b0;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end else if (rd_en && head_ctrl == '0) begin
            in_body_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_o.data = out_data_q;
  assign out_o.ctrl = out_ctrl_q;
  assign out_o.wr   = out_wr_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_pkt_rr_input_arbiter.sv
// Bench for pkt_rr_input_arbiter: vector table of single packets, hand-built
// corner sequences, and randomized rounds against a packet-level round-robin model.
module tb_pkt_rr_input_arbiter;
  localparam int DW = 64;
  localparam int CW = 8;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } w_t;

  typedef struct {
    w_t w;
    int port;
    bit eop;
  } ent_t;

  typedef struct {
    int port;
    int len;
    int exp_grant;
    int exp_lat;
    int exp_run;
  } vec_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       out_rdy;
  logic [1:0] grant;
  logic       busy;
  logic [3:0] rdy_v;
  logic       wr_d [4];
  w_t         wd_d [4];
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pkt_rr_input_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) if0 ();
  pkt_rr_input_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) if1 ();
  pkt_rr_input_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) if2 ();
  pkt_rr_input_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) if3 ();
  pkt_rr_input_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) ifo ();

  assign if0.wr = wr_d[0];  assign if0.data = wd_d[0].data;  assign if0.ctrl = wd_d[0].ctrl;
  assign if1.wr = wr_d[1];  assign if1.data = wd_d[1].data;  assign if1.ctrl = wd_d[1].ctrl;
  assign if2.wr = wr_d[2];  assign if2.data = wd_d[2].data;  assign if2.ctrl = wd_d[2].ctrl;
  assign if3.wr = wr_d[3];  assign if3.data = wd_d[3].data;  assign if3.ctrl = wd_d[3].ctrl;
  assign rdy_v  = {if3.rdy, if2.rdy, if1.rdy, if0.rdy};
  assign ifo.rdy = out_rdy;

  pkt_rr_input_arbiter #(
    .DATA_WIDTH      (DW),
    .CTRL_WIDTH      (CW),
    .FIFO_DEPTH_BITS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in0_i (if0),
    .in1_i (if1),
    .in2_i (if2),
    .in3_i (if3),
    .out_o (ifo),
    .grant (grant),
    .busy  (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: per-port packet lists, served whole in round-robin order.
  w_t   src_q [4][$];
  ent_t pw    [4][$];
  int   plen  [4][$];
  ent_t exp_q [$];
  int   m_last = 3;
  int   pkt_id = 0;

  task automatic make_pkt(input int p, input int len);
    bit   xh;
    ent_t e;
    xh = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < len; i++) begin
      if (i == 0)                          e.w.ctrl = 8'hFF;
      else if (i == len - 1)               e.w.ctrl = 8'($urandom_range(1, 255));
      else if (i == 1 && len >= 5 && xh)   e.w.ctrl = 8'($urandom_range(1, 254));
      else                                 e.w.ctrl = 8'h00;
      e.w.data = {8'(p), 8'(pkt_id), 16'(i), $urandom};
      e.port   = p;
      e.eop    = (i == len - 1);
      src_q[p].push_back(e.w);
      pw[p].push_back(e);
    end
    plen[p].push_back(len);
    pkt_id++;
  endtask

  task automatic model_schedule();
    int p;
    int n;
    for (int guard = 0; guard < 64; guard++) begin
      p = -1;
      for (int k = 1; k <= 4; k++)
        if (p < 0 && plen[(m_last + k) % 4].size() > 0) p = (m_last + k) % 4;
      if (p < 0) break;
      n = plen[p].pop_front();
      for (int i = 0; i < n; i++) exp_q.push_back(pw[p].pop_front());
      m_last = p;
    end
  endtask

  // Output monitor / scoreboard.
  bit         gap_chk   = 1'b0;
  int         prev_cyc  = -1;
  bit         prev_eop  = 1'b0;
  int         extra_cnt = 0;
  w_t         last_w    = '0;
  int         wr_cyc [$];
  ent_t       mon_e;

  always @(negedge clk) begin
    if (!gap_chk) prev_cyc = -1;
    if (ifo.wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        extra_cnt++;
      end else begin
        mon_e = exp_q.pop_front();
        check("out_word", {8'h0, ifo.ctrl, ifo.data}, {8'h0, mon_e.w});
        check("out_grant", 80'(grant), 80'(mon_e.port));
        if (gap_chk && prev_cyc >= 0)
          check("out_gap", 80'(cyc - prev_cyc), 80'(prev_eop ? 2 : 1));
        prev_cyc = cyc;
        prev_eop = mon_e.eop;
        last_w   = mon_e.w;
        wr_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive_all();
    int n;
    int left;
    n = 0;
    left = src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size();
    while (left > 0 && n < 200) begin
      for (int p = 0; p < 4; p++) begin
        if (src_q[p].size() > 0 && rdy_v[p]) begin
          wr_d[p] = 1'b1;
          wd_d[p] = src_q[p].pop_front();
        end else begin
          wr_d[p] = 1'b0;
        end
      end
      @(posedge clk); #1;
      n++;
      left = src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size();
    end
    for (int p = 0; p < 4; p++) wr_d[p] = 1'b0;
    check("drive_done", 80'(left), 80'(0));
  endtask

  task automatic wait_drain(input bit rand_rdy);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 600) begin
      if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain_left", 80'(exp_q.size()), 80'(0));
    check("extra_words", 80'(extra_cnt), 80'(0));
    extra_cnt = 0;
  endtask

  task automatic preload_run();
    out_rdy = 1'b0;
    model_schedule();
    drive_all();
    gap_chk = 1'b1;
    out_rdy = 1'b1;
    wait_drain(1'b0);
    gap_chk = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl [4];
  w_t   hold [$];
  int   k0;
  int   mask;

  initial begin
    tbl[0] = '{port:2, len:5, exp_grant:2, exp_lat:3, exp_run:5};
    tbl[1] = '{port:0, len:3, exp_grant:0, exp_lat:3, exp_run:3};
    tbl[2] = '{port:1, len:7, exp_grant:1, exp_lat:3, exp_run:7};
    tbl[3] = '{port:3, len:4, exp_grant:3, exp_lat:3, exp_run:4};

    for (int p = 0; p < 4; p++) begin
      wr_d[p] = 1'b0;
      wd_d[p] = '0;
    end
    out_rdy = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_wr",   80'(ifo.wr),   80'(0));
    check("rst_out_data", 80'(ifo.data), 80'(0));
    check("rst_out_ctrl", 80'(ifo.ctrl), 80'(0));
    check("rst_grant",    80'(grant),    80'(0));
    check("rst_busy",     80'(busy),     80'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_in_rdy",   80'(rdy_v),    80'(4'hF));

    // Isolated single packets: latency, burst length, grant.
    for (int i = 0; i < 4; i++) begin
      wr_cyc.delete();
      make_pkt(tbl[i].port, tbl[i].len);
      model_schedule();
      k0 = cyc;
      drive_all();
      wait_drain(1'b0);
      check("vec_latency", 80'(wr_cyc.size() > 0 ? wr_cyc[0] - k0 : -1), 80'(tbl[i].exp_lat));
      check("vec_count", 80'(wr_cyc.size()), 80'(tbl[i].exp_run));
      check("vec_span", 80'(wr_cyc.size() > 0 ? wr_cyc[wr_cyc.size() - 1] - wr_cyc[0] + 1 : 0),
            80'(tbl[i].exp_run));
      check("vec_grant", 80'(grant), 80'(tbl[i].exp_grant));
      check("vec_busy", 80'(busy), 80'(0));
    end

    // All four ports preloaded after queue 3 was last served.
    make_pkt(0, 3); make_pkt(1, 4); make_pkt(2, 3); make_pkt(3, 5);
    preload_run();

    // Port 3 alone, then ports 0 and 3 together: wrap-around to 0 first.
    make_pkt(3, 3);
    model_schedule();
    drive_all();
    wait_drain(1'b0);
    make_pkt(3, 4); make_pkt(0, 3);
    preload_run();

    // Downstream stall mid-packet.
    make_pkt(1, 7);
    model_schedule();
    drive_all();
    out_rdy = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check("stall_out_wr", 80'(ifo.wr), 80'(0));
      check("stall_hold", {8'h0, ifo.ctrl, ifo.data}, {8'h0, last_w});
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    wait_drain(1'b0);

    // Granted FIFO runs dry mid-packet while port 1 waits with a full packet.
    wr_cyc.delete();
    make_pkt(0, 7); make_pkt(1, 3);
    model_schedule();
    repeat (4) hold.push_front(src_q[0].pop_back());
    drive_all();
    for (int n = 0; n < 20 && wr_cyc.size() < 3; n++) begin
      @(posedge clk); #1;
    end
    check("starve_words_out", 80'(wr_cyc.size()), 80'(3));
    repeat (5) begin
      @(negedge clk);
      check("starve_out_wr", 80'(ifo.wr), 80'(0));
      check("starve_grant",  80'(grant),  80'(0));
      check("starve_busy",   80'(busy),   80'(1));
      @(posedge clk); #1;
    end
    while (hold.size() > 0) src_q[0].push_back(hold.pop_front());
    drive_all();
    wait_drain(1'b0);

    // Asynchronous reset in the middle of a packet.
    make_pkt(2, 7);
    model_schedule();
    drive_all();
    reset = 1'b0;
    #1;
    check("mid_rst_out_wr",   80'(ifo.wr),   80'(0));
    check("mid_rst_out_data", 80'(ifo.data), 80'(0));
    check("mid_rst_out_ctrl", 80'(ifo.ctrl), 80'(0));
    check("mid_rst_busy",     80'(busy),     80'(0));
    check("mid_rst_grant",    80'(grant),    80'(0));
    check("mid_rst_in_rdy",   80'(rdy_v),    80'(4'hF));
    exp_q.delete();
    for (int p = 0; p < 4; p++) begin
      src_q[p].delete();
      pw[p].delete();
      plen[p].delete();
    end
    m_last = 3;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    make_pkt(2, 3); make_pkt(1, 4); make_pkt(0, 3);
    preload_run();

    // Randomized rounds with random downstream backpressure.
    for (int r = 0; r < 25; r++) begin
      mask = int'($urandom_range(1, 15));
      out_rdy = 1'b0;
      for (int p = 0; p < 4; p++) begin
        if (mask[p]) begin
          if ($urandom_range(0, 1) == 1) begin
            make_pkt(p, 3);
            make_pkt(p, 3);
          end else begin
            make_pkt(p, int'($urandom_range(3, 7)));
          end
        end
      end
      model_schedule();
      drive_all();
      wait_drain(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
